// File: rtl/count_display_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : count_display_if                                             |
// | Purpose   : Load/result handshake between the event counter and the      |
// |             count_display block.                                         |
// |   count_in  binary value offered for display (counter -> display)        |
// |   load      1-cycle request to sample count_in (counter -> display)      |
// |   busy      conversion in progress, load ignored (display -> counter)    |
// |   done      1-cycle pulse, bcd updated this cycle (display -> counter)    |
// |   bcd       converted value {hundreds,tens,ones} (display -> counter)     |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface count_display_if #(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]    count_in;
  logic                load;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;

  // Counter side
  modport master (
    output count_in,
    output load,
    input  busy,
    input  done,
    input  bcd
  );

  // Display side
  modport slave (
    input  count_in,
    input  load,
    output busy,
    output done,
    output bcd
  );
endinterface
`default_nettype wire

// File: rtl/count_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : count_display                                                |
// | Purpose   : Samples a binary event count on a load pulse, converts it to |
// |             BCD with a sequential shift-add-3 engine, and scans the      |
// |             digits onto a multiplexed 7-segment display with leading-    |
// |             zero blanking.                                               |
// | Ports     :                                                              |
// |   clk       system clock, all state on posedge                           |
// |   rst       asynchronous reset, active-low                               |
// |   bus       count_in/load in, busy/done/bcd out (count_display_if.slave) |
// |   an        digit enables, active-high, one-hot or all-0 (an[0] = ones)  |
// |   seg       segments {dp,g,f,e,d,c,b,a}, active-high, dp always 0       |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module count_display #(
  parameter int WIDTH    = 9,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 100_000
) (
  input  wire               clk,
  input  wire               rst,
  count_display_if.slave    bus,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg
);

  localparam int c_BCD_W  = 4 * DIGITS;
  localparam int c_ITER_W = $clog2(WIDTH + 1);
  localparam int c_SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [c_ITER_W-1:0] c_LAST_ITER = c_ITER_W'(WIDTH - 1);
  localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);
  localparam logic [c_DIG_W-1:0]  c_DIG_LAST  = c_DIG_W'(DIGITS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Conversion state
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [WIDTH-1:0]      r_bin;
  logic [c_BCD_W-1:0]    r_scratch;
  logic [c_ITER_W-1:0]   r_iter;
  logic [c_BCD_W-1:0]    r_bcd;
  logic                  r_busy;
  logic                  r_done;

  state_t                w_state_nxt;
  logic [WIDTH-1:0]      w_bin_nxt;
  logic [c_BCD_W-1:0]    w_scratch_nxt;
  logic [c_ITER_W-1:0]   w_iter_nxt;
  logic [c_BCD_W-1:0]    w_bcd_nxt;
  logic                  w_done_nxt;

  logic [c_BCD_W-1:0]       w_scratch_adj;
  logic [c_BCD_W+WIDTH-1:0] w_shifted;

  // Add 3 to every nibble that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign w_scratch_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5)
                                    ? r_scratch[4*gi +: 4] + 4'd3
                                    : r_scratch[4*gi +: 4];
  end

  assign w_shifted = {w_scratch_adj, r_bin} << 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_bin     <= '0;
      r_scratch <= '0;
      r_iter    <= '0;
      r_bcd     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bin     <= w_bin_nxt;
      r_scratch <= w_scratch_nxt;
      r_iter    <= w_iter_nxt;
      r_bcd     <= w_bcd_nxt;
      r_busy    <= (w_state_nxt == S_CONV);
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bin_nxt     = r_bin;
    w_scratch_nxt = r_scratch;
    w_iter_nxt    = r_iter;
    w_bcd_nxt     = r_bcd;
    w_done_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // A load in the done cycle lands here too, since the FSM is
        // already back in IDLE by then.
        if (bus.load) begin
          w_bin_nxt     = bus.count_in;
          w_scratch_nxt = '0;
          w_iter_nxt    = '0;
          w_state_nxt   = S_CONV;
        end
      end
      S_CONV: begin
        w_bin_nxt     = w_shifted[WIDTH-1:0];
        w_scratch_nxt = w_shifted[c_BCD_W+WIDTH-1 -: c_BCD_W];
        w_iter_nxt    = r_iter + c_ITER_W'(1);
        // The last shift publishes the finished digits in one step, so bcd
        // never exposes an intermediate value.
        if (r_iter == c_LAST_ITER) begin
          w_bcd_nxt   = w_shifted[c_BCD_W+WIDTH-1 -: c_BCD_W];
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [c_SCAN_W-1:0] r_scan_cnt;
  logic [c_DIG_W-1:0]  r_digit;
  logic [DIGITS-1:0]   r_an;
  logic [7:0]          r_seg;

  logic [3:0]          w_nib;
  logic [DIGITS-1:0]   w_an_cur;
  logic                w_upper_zero;
  logic                w_blank;
  logic [7:0]          w_seg_dec;

  // Walk from the most significant digit down, tracking whether every digit
  // seen so far is zero; the selected digit is blanked when it and all
  // digits above it are zero. The ones digit is always shown.
  always_comb begin
    w_nib        = 4'd0;
    w_an_cur     = '0;
    w_upper_zero = 1'b1;
    w_blank      = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      w_upper_zero = w_upper_zero && (r_bcd[4*d +: 4] == 4'd0);
      if (r_digit == c_DIG_W'(d)) begin
        w_nib       = r_bcd[4*d +: 4];
        w_an_cur[d] = 1'b1;
        w_blank     = (d != 0) && w_upper_zero;
      end
    end
  end

  always_comb begin
    w_seg_dec = 8'h00;
    case (w_nib)
      4'd0:    w_seg_dec = 8'h3F;
      4'd1:    w_seg_dec = 8'h06;
      4'd2:    w_seg_dec = 8'h5B;
      4'd3:    w_seg_dec = 8'h4F;
      4'd4:    w_seg_dec = 8'h66;
      4'd5:    w_seg_dec = 8'h6D;
      4'd6:    w_seg_dec = 8'h7D;
      4'd7:    w_seg_dec = 8'h07;
      4'd8:    w_seg_dec = 8'h7F;
      4'd9:    w_seg_dec = 8'h6F;
      default: w_seg_dec = 8'h00;
    endcase
  end

  // The scan phase runs freely and is only cleared by reset, so a new bcd
  // simply shows up in whichever slot is current.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan_cnt <= '0;
      r_digit    <= '0;
      r_an       <= '0;
      r_seg      <= 8'h00;
    end else begin
      if (r_scan_cnt == c_SCAN_LAST) begin
        r_scan_cnt <= '0;
        r_digit    <= (r_digit == c_DIG_LAST) ? '0 : r_digit + c_DIG_W'(1);
      end else begin
        r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
      end
      r_an  <= w_blank ? '0 : w_an_cur;
      r_seg <= w_blank ? 8'h00 : w_seg_dec;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_count_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_count_display                                             |
// | Purpose   : Self-checking bench for count_display with a short scan      |
// |             period; expected digits and display slots come from decimal  |
// |             arithmetic on the loaded value.                              |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_count_display;

  localparam int SD = 4;

  logic       clk;
  logic       rst;
  logic [2:0] an;
  logic [7:0] seg;

  int tests;
  int fails;
  int edges;

  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  count_display_if #(.WIDTH(9), .DIGITS(3)) bus ();

  count_display #(
    .WIDTH   (9),
    .DIGITS  (3),
    .SCAN_DIV(SD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .an  (an),
    .seg (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges seen since reset was last released; the scan slot follows
  // directly from this count.
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // {an, seg} expected while slot d is shown for value v: a slot is lit only
  // up to the most significant nonzero digit (slot 0 always lit).
  function automatic logic [10:0] exp_disp(input int v, input int d);
    int dig [3];
    int top;
    dig[0] = v % 10;
    dig[1] = (v / 10) % 10;
    dig[2] = v / 100;
    top = (v >= 100) ? 2 : ((v >= 10) ? 1 : 0);
    if (d > top) return 11'd0;
    return {3'(1 << d), seg_tab[dig[d]]};
  endfunction

  // Issue one load of v and follow it until the cycle after done.
  task automatic convert(input logic [8:0] v, output int busy_n, output int done_n,
                         output logic [11:0] bcd_o, output bit to);
    @(negedge clk);
    bus.count_in = v;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
    bus.count_in = 9'($urandom);
    busy_n = 0;
    done_n = 0;
    bcd_o  = 12'h000;
    to     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        bcd_o = bus.bcd;
        to    = 1'b0;
      end else if (!to) begin
        break;
      end
      bus.count_in = 9'($urandom);
      @(negedge clk);
    end
  endtask

  // Watch one full scan rotation and compare each slot with the model.
  task automatic test_scan(input int v, input string tag);
    logic [10:0] exp;
    for (int i = 0; i < 3 * SD; i++) begin
      @(negedge clk);
      exp = exp_disp(v, ((edges - 1) / SD) % 3);
      tests++;
      if ({an, seg} !== exp) begin
        fails++;
        $display("FAIL scan_%s v=%0d: an=%b seg=%h, expected an=%b seg=%h",
                 tag, v, an, seg, exp[10:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_conv_value(input int v, input string tag);
    int busy_n, done_n;
    logic [11:0] b;
    bit to;
    convert(9'(v), busy_n, done_n, b, to);
    tests++;
    if (to || busy_n !== 9 || done_n !== 1) begin
      fails++;
      $display("FAIL timing_%s v=%0d: busy_cycles=%0d done_cycles=%0d timeout=%0d, expected 9/1/0",
               tag, v, busy_n, done_n, to);
    end
    tests++;
    if (b !== to_bcd(v)) begin
      fails++;
      $display("FAIL bcd_%s v=%0d: got %h, expected %h", tag, v, b, to_bcd(v));
    end
  endtask

  task automatic test_reset;
    rst          = 1'b0;
    bus.load     = 1'b0;
    bus.count_in = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({an, seg, bus.bcd, bus.busy, bus.done} !== 25'd0) begin
      fails++;
      $display("FAIL reset_state: an=%b seg=%h bcd=%h busy=%b done=%b, expected all 0",
               an, seg, bus.bcd, bus.busy, bus.done);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (an !== 3'b001 || seg !== 8'h3F) begin
      fails++;
      $display("FAIL reset_release: an=%b seg=%h, expected an=001 seg=3f", an, seg);
    end
  endtask

  task automatic test_convert;
    test_conv_value(345, "convert");
    test_scan(345, "convert");
  endtask

  task automatic test_reset_midrun;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({an, seg, bus.bcd, bus.busy, bus.done} !== 25'd0) begin
      fails++;
      $display("FAIL reset_midrun: an=%b seg=%h bcd=%h busy=%b done=%b, expected all 0",
               an, seg, bus.bcd, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (an !== 3'b001 || seg !== 8'h3F) begin
      fails++;
      $display("FAIL reset_midrun_release: an=%b seg=%h, expected an=001 seg=3f", an, seg);
    end
  endtask

  task automatic test_bounds;
    test_conv_value(0, "zero");
    test_scan(0, "zero");
    test_conv_value(511, "max");
    test_scan(511, "max");
  endtask

  task automatic test_blanking;
    test_conv_value(7, "blank7");
    test_scan(7, "blank7");
    test_conv_value(40, "blank40");
    test_scan(40, "blank40");
  endtask

  task automatic test_handshake;
    int n;
    int v1, v2, v3;
    v1 = 123; v2 = 456; v3 = 278;
    @(negedge clk);
    bus.count_in = 9'(v1);
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL hs_busy_mid: busy=%b, expected 1", bus.busy);
    end
    bus.count_in = 9'(v2);
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    n = 0;
    while (!bus.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.done !== 1'b1 || bus.bcd !== to_bcd(v1) || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL hs_drop: done=%b bcd=%h busy=%b, expected done=1 bcd=%h busy=0",
               bus.done, bus.bcd, bus.busy, to_bcd(v1));
    end
    // Load in the done cycle must be accepted.
    bus.count_in = 9'(v3);
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL hs_done_load: busy=%b, expected 1", bus.busy);
    end
    n = 0;
    while (!bus.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.done !== 1'b1 || bus.bcd !== to_bcd(v3)) begin
      fails++;
      $display("FAIL hs_done_result: done=%b bcd=%h, expected done=1 bcd=%h",
               bus.done, bus.bcd, to_bcd(v3));
    end
  endtask

  task automatic test_abort;
    @(negedge clk);
    bus.count_in = 9'd482;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_busy: busy=%b, expected 1", bus.busy);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({an, seg, bus.bcd, bus.busy, bus.done} !== 25'd0) begin
      fails++;
      $display("FAIL abort_reset: an=%b seg=%h bcd=%h busy=%b done=%b, expected all 0",
               an, seg, bus.bcd, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b1;
    test_conv_value(100, "abort");
    test_scan(100, "abort");
  endtask

  task automatic test_random;
    int v;
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 511));
      test_conv_value(v, "rand");
      if (i % 2 == 0) test_scan(v, "rand");
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_convert();
    test_reset_midrun();
    test_bounds();
    test_blanking();
    test_handshake();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
